// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: tracks EX/MEM/WB destination registers, drives the
// operand forwarding selects, stalls ID on load-use and squashes ID on taken branches.
module ex_hazard_ctrl #(
  parameter int XLEN_REGS = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [XLEN_REGS-1:0] id_rs1,
  input  logic [XLEN_REGS-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [XLEN_REGS-1:0] id_rd,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic                 ex_branch_taken,
  input  logic                 mem_stall,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 ex_valid,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_EX = 2'd1;
  localparam logic [1:0] SEL_WB = 2'd2;

  // EX tracker entry
  logic                 ex_v, ex_use1, ex_use2, ex_we, ex_load;
  logic [XLEN_REGS-1:0] ex_rs1, ex_rs2, ex_rd;
  // MEM and WB tracker entries
  logic                 mem_v, mem_we, mem_load;
  logic [XLEN_REGS-1:0] mem_rd;
  logic                 wb_v, wb_we;
  logic [XLEN_REGS-1:0] wb_rd;

  logic mem_match_a, mem_match_b, wb_match_a, wb_match_b;
  logic load_use, advance, bubble;

  assign mem_match_a = mem_v & mem_we & (mem_rd == ex_rs1) & (ex_rs1 != '0);
  assign mem_match_b = mem_v & mem_we & (mem_rd == ex_rs2) & (ex_rs2 != '0);
  assign wb_match_a  = wb_v & wb_we & (wb_rd == ex_rs1) & (ex_rs1 != '0);
  assign wb_match_b  = wb_v & wb_we & (wb_rd == ex_rs2) & (ex_rs2 != '0);

  // A load sitting in MEM has no data yet, so it can only be forwarded from WB.
  always_comb begin
    fwd_a_sel = SEL_RF;
    if (ex_use1 && ex_rs1 != '0) begin
      if (mem_match_a && !mem_load) fwd_a_sel = SEL_EX;
      else if (wb_match_a)          fwd_a_sel = SEL_WB;
    end
  end

  always_comb begin
    fwd_b_sel = SEL_RF;
    if (ex_use2 && ex_rs2 != '0) begin
      if (mem_match_b && !mem_load) fwd_b_sel = SEL_EX;
      else if (wb_match_b)          fwd_b_sel = SEL_WB;
    end
  end

  assign load_use = ex_v & ex_load & ex_we & (ex_rd != '0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign flush_id = ex_branch_taken & ex_v & ~mem_stall;
  assign stall_id = mem_stall | (load_use & ~flush_id);
  assign ex_valid = ex_v;
  assign advance  = ~mem_stall;
  assign bubble   = flush_id | load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v     <= 1'b0;
      ex_use1  <= 1'b0;
      ex_use2  <= 1'b0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      mem_v    <= 1'b0;
      mem_we   <= 1'b0;
      mem_load <= 1'b0;
      mem_rd   <= '0;
      wb_v     <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
    end else if (advance) begin
      wb_v     <= mem_v;
      wb_we    <= mem_we;
      wb_rd    <= mem_rd;
      mem_v    <= ex_v;
      mem_we   <= ex_we;
      mem_load <= ex_load;
      mem_rd   <= ex_rd;
      if (bubble) begin
        ex_v    <= 1'b0;
        ex_use1 <= 1'b0;
        ex_use2 <= 1'b0;
        ex_we   <= 1'b0;
        ex_load <= 1'b0;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
        ex_rd   <= '0;
      end else begin
        ex_v    <= id_valid;
        ex_use1 <= id_use_rs1;
        ex_use2 <= id_use_rs2;
        ex_we   <= id_we;
        ex_load <= id_is_load;
        ex_rs1  <= id_rs1;
        ex_rs2  <= id_rs2;
        ex_rd   <= id_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (advance && load_use && !flush_id && stall_count != '1) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use stall, flush, freeze,
// reset and counter saturation (counter width reduced to reach saturation quickly).
module tb_ex_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_branch_taken, mem_stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall_id, flush_id, ex_valid;
  logic [CW-1:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  ex_hazard_ctrl #(.XLEN_REGS(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_id(stall_id), .flush_id(flush_id), .ex_valid(ex_valid),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks occur 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic do_reset();
    ex_branch_taken = 1'b0;
    mem_stall = 1'b0;
    rst = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (fwd_a_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_fwd_a got %0d exp 0", fwd_a_sel); end
    tests_run++; if (fwd_b_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_fwd_b got %0d exp 0", fwd_b_sel); end
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b exp 0", stall_id); end
    tests_run++; if (flush_id !== 1'b0) begin tests_failed++; $display("FAIL reset_flush got %0b exp 0", flush_id); end
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_valid got %0b exp 0", ex_valid); end
    tests_run++; if (stall_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", stall_count); end
  endtask

  task automatic test_ex_forward();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5
    tick();
    set_id(1'b1, 5'd5, 5'd9, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);  // consumer of x5 on rs1
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL exfwd_stall got %0b exp 0", stall_id); end
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tests_run++; if (fwd_a_sel !== 2'd1) begin tests_failed++; $display("FAIL exfwd_a got %0d exp 1", fwd_a_sel); end
    tests_run++; if (fwd_b_sel !== 2'd0) begin tests_failed++; $display("FAIL exfwd_b got %0d exp 0", fwd_b_sel); end
    tests_run++; if (ex_valid !== 1'b1) begin tests_failed++; $display("FAIL exfwd_valid got %0b exp 1", ex_valid); end
  endtask

  task automatic test_wb_forward();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);  // writer x7
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);  // unrelated
    tick();
    set_id(1'b1, 5'd4, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // consumer rs2=x7
    tick();
    tests_run++; if (fwd_b_sel !== 2'd2) begin tests_failed++; $display("FAIL wbfwd_b got %0d exp 2", fwd_b_sel); end
    tests_run++; if (fwd_a_sel !== 2'd0) begin tests_failed++; $display("FAIL wbfwd_a got %0d exp 0", fwd_a_sel); end
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    tests_run++; if (fwd_b_sel !== 2'd1) begin tests_failed++; $display("FAIL both_writers_b got %0d exp 1", fwd_b_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);  // lw x3
    tick();
    set_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);  // consumer of x3
    tests_run++; if (stall_id !== 1'b1) begin tests_failed++; $display("FAIL lu_stall got %0b exp 1", stall_id); end
    tests_run++; if (stall_count !== 4'd0) begin tests_failed++; $display("FAIL lu_count0 got %0d exp 0", stall_count); end
    tick();
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble got %0b exp 0", ex_valid); end
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL lu_stall_once got %0b exp 0", stall_id); end
    tests_run++; if (stall_count !== 4'd1) begin tests_failed++; $display("FAIL lu_count1 got %0d exp 1", stall_count); end
    tick();
    tests_run++; if (fwd_a_sel !== 2'd2) begin tests_failed++; $display("FAIL lu_fwd_a got %0d exp 2", fwd_a_sel); end
    tests_run++; if (ex_valid !== 1'b1) begin tests_failed++; $display("FAIL lu_consumer_valid got %0b exp 1", ex_valid); end
    tests_run++; if (stall_count !== 4'd1) begin tests_failed++; $display("FAIL lu_count_hold got %0d exp 1", stall_count); end
  endtask

  task automatic test_branch_flush();
    // continues from test_load_use: stall_count is 1 and must stay 1
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    tests_run++; if (flush_id !== 1'b1) begin tests_failed++; $display("FAIL br_flush got %0b exp 1", flush_id); end
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL br_stall got %0b exp 0", stall_id); end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL br_bubble got %0b exp 0", ex_valid); end
    tests_run++; if (stall_count !== 4'd1) begin tests_failed++; $display("FAIL br_count got %0d exp 1", stall_count); end
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);  // writes x0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);  // load x0 reading x0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL x0_stall got %0b exp 0", stall_id); end
    tests_run++; if (fwd_a_sel !== 2'd0) begin tests_failed++; $display("FAIL x0_fwd_a got %0d exp 0", fwd_a_sel); end
    tests_run++; if (fwd_b_sel !== 2'd0) begin tests_failed++; $display("FAIL x0_fwd_b got %0d exp 0", fwd_b_sel); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (stall_id !== 1'b1) begin tests_failed++; $display("FAIL frz_stall[%0d] got %0b exp 1", i, stall_id); end
      tests_run++; if (fwd_a_sel !== 2'd1) begin tests_failed++; $display("FAIL frz_fwd_a[%0d] got %0d exp 1", i, fwd_a_sel); end
      tests_run++; if (ex_valid !== 1'b1) begin tests_failed++; $display("FAIL frz_valid[%0d] got %0b exp 1", i, ex_valid); end
      tick();
    end
    mem_stall = 1'b0;
    #1;
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL frz_release got %0b exp 0", stall_id); end
    tests_run++; if (fwd_a_sel !== 2'd1) begin tests_failed++; $display("FAIL frz_held_fwd got %0d exp 1", fwd_a_sel); end
    tick();
    tests_run++; if (fwd_a_sel !== 2'd0) begin tests_failed++; $display("FAIL frz_advance_fwd got %0d exp 0", fwd_a_sel); end
  endtask

  task automatic test_reset_during_stall();
    do_reset();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();                                                   // count -> 1, bubble in EX
    tick();                                                   // consumer in EX, load in WB
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    mem_stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    tests_run++; if (fwd_a_sel !== 2'd0) begin tests_failed++; $display("FAIL rst_mid_fwd_a got %0d exp 0", fwd_a_sel); end
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid got %0b exp 0", ex_valid); end
    tests_run++; if (stall_count !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_count got %0d exp 0", stall_count); end
    tests_run++; if (flush_id !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flush got %0b exp 0", flush_id); end
    tests_run++; if (stall_id !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_stall got %0b exp 1", stall_id); end
    mem_stall = 1'b0;
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL rst_release_stall got %0b exp 0", stall_id); end
  endtask

  task automatic test_back_to_back();
    // a load that reads its own destination, held in ID, stalls every other cycle
    do_reset();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tests_run++;
      if (stall_id !== logic'(i % 2)) begin
        tests_failed++; $display("FAIL b2b_stall[%0d] got %0b exp %0b", i, stall_id, i % 2);
      end
      tick();
    end
    tests_run++; if (stall_count !== 4'hF) begin tests_failed++; $display("FAIL b2b_saturate got %0d exp 15", stall_count); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_branch_flush();
    test_x0();
    test_mem_stall();
    test_reset_during_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
